unified_mem_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch

---
 rtl/unified_mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port, fixed-latency memory between the instruction-fetch
// port and the data port. One transaction is in flight at a time and moves
// through IDLE -> BUSY -> RESP. The data port has priority. A starvation
// counter hands one arbitration to fetch after STARVE_MAX consecutive losses.
// Optional build macro: ARB_PERF_CNT_EN enables the conflict_cnt and
// if_wait_cnt performance counters. Without it both ports read 32'd0.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [31:0]       conflict_cnt,
    output logic [31:0]       if_wait_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

    state_t            state;
    state_t            state_next;
    logic [3:0]        lat_cnt;
    logic [3:0]        starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              owner_if_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_win;
    logic              d_win;
    logic              capture;

    // Arbitration: only in IDLE; fetch wins when alone or when it has been starved long enough
    always_comb begin
        if_win = 1'b0;
        d_win  = 1'b0;
        if (state == IDLE) begin
            if (if_req && (!d_req || starve_cnt == STARVE_TOP)) begin
                if_win = 1'b1;
            end else if (d_req) begin
                d_win = 1'b1;
            end
        end
    end

    // Next-state logic; capture marks the last BUSY cycle when memory data is valid
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (if_win || d_win) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (lat_cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Transaction latch and latency countdown; port inputs are not looked at again after the grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            owner_if_q <= 1'b0;
            lat_cnt    <= 4'd0;
        end else if (if_win) begin
            addr_q     <= if_addr;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            owner_if_q <= 1'b1;
            lat_cnt    <= LAT_LOAD;
        end else if (d_win) begin
            addr_q     <= d_addr;
            wdata_q    <= d_wdata;
            we_q       <= d_we;
            owner_if_q <= 1'b0;
            lat_cnt    <= LAT_LOAD;
        end else if (state == BUSY && lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
        end
    end

    // Starvation tracking: counts data wins that beat a waiting fetch, cleared when fetch wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (if_win) begin
            starve_cnt <= 4'd0;
        end else if (d_win && if_req && starve_cnt != STARVE_TOP) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Read data capture into the owner's holding register; stores return zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (capture) begin
            if (owner_if_q) begin
                if_rdata_q <= m_rdata;
            end else if (we_q) begin
                d_rdata_q <= '0;
            end else begin
                d_rdata_q <= m_rdata;
            end
        end
    end

    assign if_gnt    = if_win;
    assign d_gnt     = d_win;
    assign m_req     = (state == BUSY);
    assign m_we      = (state == BUSY) && we_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign if_rvalid = (state == RESP) && owner_if_q;
    assign d_rvalid  = (state == RESP) && !owner_if_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_q;
    logic [31:0] if_wait_q;

    // Performance counters: contention seen in IDLE, and every cycle fetch waits without a grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= 32'd0;
            if_wait_q  <= 32'd0;
        end else begin
            if (state == IDLE && if_req && d_req) begin
                conflict_q <= conflict_q + 32'd1;
            end
            if (if_req && !if_win) begin
                if_wait_q <= if_wait_q + 32'd1;
            end
        end
    end

    assign conflict_cnt = conflict_q;
    assign if_wait_cnt  = if_wait_q;
`else
    assign conflict_cnt = 32'd0;
    assign if_wait_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter (MEM_LAT=2, STARVE_MAX=4).
// Directed scenarios followed by randomized request traffic, all checked
// against a transaction-timeline reference model.
module tb_unified_mem_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic [31:0] conflict_cnt;
    logic [31:0] if_wait_cnt;

    unified_mem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_gnt       (d_gnt),
        .d_rvalid    (d_rvalid),
        .d_rdata     (d_rdata),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .conflict_cnt(conflict_cnt),
        .if_wait_cnt (if_wait_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural memory: 256 words aliased by address bits [9:2], unwritten words hold a hash
    logic [31:0] memArr [0:255];
    bit          memVld [0:255];
    int          memCnt;

    function automatic logic [31:0] memRead(input logic [31:0] a);
        logic [7:0] idx;
        idx = a[9:2];
        if (memVld[idx]) return memArr[idx];
        if (idx == 8'h10) return 32'h00A00093;
        return ({24'd0, idx} * 32'h9E3779B1) ^ 32'h0F0F1234;
    endfunction

    // Memory timing: data is only valid in the MEM_LAT-th cycle of m_req, garbage otherwise
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            memCnt <= 0;
        end else begin
            if (m_req && m_we && memCnt == MEM_LAT - 1) begin
                memArr[m_addr[9:2]] <= m_wdata;
                memVld[m_addr[9:2]] <= 1'b1;
            end
            memCnt <= m_req ? memCnt + 1 : 0;
        end
    end

    always_comb begin
        if (m_req && memCnt == MEM_LAT - 1) m_rdata = memRead(m_addr);
        else m_rdata = 32'hBAD0BAD0 ^ m_addr;
    end

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: a transaction occupies the memory for MEM_LAT+1 cycles after its grant
    int          busyLeft;
    int          starve;
    bit          ownIf;
    bit          ownWe;
    logic [31:0] ownAddr;
    logic [31:0] ownWdata;
    logic [31:0] expIfRdata;
    logic [31:0] expDRdata;
    logic [31:0] expConf;
    logic [31:0] expWait;
    bit          lastIfGnt;
    bit          lastDGnt;
    bit          gntSeq[$];

    task automatic modelReset();
        busyLeft   = 0;
        starve     = 0;
        ownIf      = 1'b0;
        ownWe      = 1'b0;
        ownAddr    = 32'd0;
        ownWdata   = 32'd0;
        expIfRdata = 32'd0;
        expDRdata  = 32'd0;
        expConf    = 32'd0;
        expWait    = 32'd0;
        lastIfGnt  = 1'b0;
        lastDGnt   = 1'b0;
    endtask

    task automatic evalCycle();
        bit idle, eIg, eDg, eMreq, eIrv, eDrv;
        if (rst) begin
            checkOutput("rst_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
            checkOutput("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
            checkOutput("rst_m_req", {30'd0, m_req, m_we}, 32'd0);
            checkOutput("rst_m_addr", m_addr, 32'd0);
            checkOutput("rst_m_wdata", m_wdata, 32'd0);
            checkOutput("rst_if_rdata", if_rdata, 32'd0);
            checkOutput("rst_d_rdata", d_rdata, 32'd0);
            checkOutput("rst_conflict_cnt", conflict_cnt, 32'd0);
            checkOutput("rst_if_wait_cnt", if_wait_cnt, 32'd0);
            modelReset();
            return;
        end
        idle = (busyLeft == 0);
        eIg  = 1'b0;
        eDg  = 1'b0;
        if (idle) begin
            if (if_req && (!d_req || starve == STARVE_MAX)) eIg = 1'b1;
            else if (d_req) eDg = 1'b1;
        end
        eMreq = (busyLeft >= 2);
        eIrv  = (busyLeft == 1) && ownIf;
        eDrv  = (busyLeft == 1) && !ownIf;
        checkOutput("if_gnt", {31'd0, if_gnt}, {31'd0, eIg});
        checkOutput("d_gnt", {31'd0, d_gnt}, {31'd0, eDg});
        checkOutput("m_req", {31'd0, m_req}, {31'd0, eMreq});
        checkOutput("m_we", {31'd0, m_we}, {31'd0, eMreq && ownWe});
        if (eMreq) begin
            checkOutput("m_addr", m_addr, ownAddr);
            if (ownWe) checkOutput("m_wdata", m_wdata, ownWdata);
        end
        checkOutput("if_rvalid", {31'd0, if_rvalid}, {31'd0, eIrv});
        checkOutput("d_rvalid", {31'd0, d_rvalid}, {31'd0, eDrv});
        checkOutput("if_rdata", if_rdata, expIfRdata);
        checkOutput("d_rdata", d_rdata, expDRdata);
`ifdef ARB_PERF_CNT_EN
        checkOutput("conflict_cnt", conflict_cnt, expConf);
        checkOutput("if_wait_cnt", if_wait_cnt, expWait);
`else
        checkOutput("conflict_cnt", conflict_cnt, 32'd0);
        checkOutput("if_wait_cnt", if_wait_cnt, 32'd0);
`endif
        if (idle && if_req && d_req) expConf = expConf + 32'd1;
        if (if_req && !eIg) expWait = expWait + 32'd1;
        if (busyLeft == 2) begin
            if (ownIf) expIfRdata = memRead(ownAddr);
            else expDRdata = ownWe ? 32'd0 : memRead(ownAddr);
        end
        if (busyLeft > 0) busyLeft--;
        if (eIg) begin
            ownIf    = 1'b1;
            ownWe    = 1'b0;
            ownAddr  = if_addr;
            starve   = 0;
            busyLeft = MEM_LAT + 1;
        end else if (eDg) begin
            ownIf    = 1'b0;
            ownWe    = d_we;
            ownAddr  = d_addr;
            ownWdata = d_wdata;
            if (if_req && starve < STARVE_MAX) starve++;
            busyLeft = MEM_LAT + 1;
        end
        lastIfGnt = if_gnt;
        lastDGnt  = d_gnt;
        if (if_gnt) gntSeq.push_back(1'b1);
        else if (d_gnt) gntSeq.push_back(1'b0);
    endtask

    task automatic sample();
        @(negedge clk);
        evalCycle();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic resetPulse();
        if_req = 1'b0;
        d_req  = 1'b0;
        rst    = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Random masters: hold a request until granted, occasionally withdraw it, rare async resets
    task automatic applyStimulus();
        if (rst) begin
            rst = 1'b0;
        end else if ($urandom_range(0, 299) == 0) begin
            rst    = 1'b1;
            if_req = 1'b0;
            d_req  = 1'b0;
            return;
        end
        if (if_req && !lastIfGnt) begin
            if ($urandom_range(0, 15) == 0) if_req = 1'b0;
        end else begin
            if_req  = 1'($urandom_range(0, 1));
            if_addr = $urandom;
        end
        if (d_req && !lastDGnt) begin
            if ($urandom_range(0, 15) == 0) d_req = 1'b0;
        end else begin
            d_req   = 1'($urandom_range(0, 1));
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = $urandom;
            d_wdata = $urandom;
        end
    endtask

    initial begin
        bit ig, dg;
        modelReset();
        #2;
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Single fetch of 0x40
        if_req  = 1'b1;
        if_addr = 32'h40;
        sample();
        checkOutput("t1_if_gnt", {31'd0, if_gnt}, 32'd1);
        advance();
        if_req = 1'b0;
        step();
        step();
        sample();
        checkOutput("t1_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        checkOutput("t1_if_rdata", if_rdata, 32'h00A00093);
        advance();
        step();

        // Simultaneous fetch and load: data first, fetch in the following IDLE
        resetPulse();
        if_req  = 1'b1;
        if_addr = 32'h80;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h100;
        sample();
        checkOutput("t2_d_gnt", {30'd0, if_gnt, d_gnt}, 32'd1);
        advance();
        d_req = 1'b0;
        step();
        step();
        sample();
        checkOutput("t2_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        advance();
        sample();
        checkOutput("t2_if_gnt", {31'd0, if_gnt}, 32'd1);
        advance();
        if_req = 1'b0;
        step();
        step();
        sample();
`ifdef ARB_PERF_CNT_EN
        checkOutput("t2_conflict_cnt", conflict_cnt, 32'd1);
        checkOutput("t2_if_wait_cnt", if_wait_cnt, 32'd4);
`else
        checkOutput("t2_conflict_cnt", conflict_cnt, 32'd0);
        checkOutput("t2_if_wait_cnt", if_wait_cnt, 32'd0);
`endif
        advance();

        // Continuous data pressure: four data grants, then fetch, then data again
        resetPulse();
        gntSeq.delete();
        if_req  = 1'b1;
        if_addr = 32'h200;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h300;
        for (int c = 0; c < 80 && gntSeq.size() < 6; c++) begin
            sample();
            ig = if_gnt;
            dg = d_gnt;
            advance();
            if (ig) if_addr = if_addr + 32'd4;
            if (dg) d_addr = d_addr + 32'd4;
        end
        checkOutput("t3_grant_count", gntSeq.size(), 32'd6);
        if (gntSeq.size() == 6) begin
            for (int i = 0; i < 4; i++) checkOutput("t3_data_grant", {31'd0, gntSeq[i]}, 32'd0);
            checkOutput("t3_fetch_grant", {31'd0, gntSeq[4]}, 32'd1);
            checkOutput("t3_after_fetch", {31'd0, gntSeq[5]}, 32'd0);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Store of 0xDEADBEEF to 0x100
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h100;
        d_wdata = 32'hDEADBEEF;
        sample();
        checkOutput("t4_d_gnt", {31'd0, d_gnt}, 32'd1);
        advance();
        d_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            checkOutput("t4_m_we", {31'd0, m_we}, 32'd1);
            checkOutput("t4_m_wdata", m_wdata, 32'hDEADBEEF);
            advance();
        end
        sample();
        checkOutput("t4_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        checkOutput("t4_d_rdata", d_rdata, 32'd0);
        checkOutput("t4_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        advance();
        step();

        // Reset in the second BUSY cycle, then a clean fetch of 0x44
        if_req  = 1'b1;
        if_addr = 32'h44;
        step();
        if_req = 1'b0;
        step();
        rst = 1'b1;
        sample();
        checkOutput("t5_m_req", {31'd0, m_req}, 32'd0);
        advance();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            checkOutput("t5_no_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
            advance();
        end
        if_req  = 1'b1;
        if_addr = 32'h44;
        sample();
        checkOutput("t5_if_gnt", {31'd0, if_gnt}, 32'd1);
        advance();
        if_req = 1'b0;
        step();
        step();
        sample();
        checkOutput("t5_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        checkOutput("t5_if_rdata", if_rdata, memRead(32'h44));
        advance();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            sample();
            advance();
            applyStimulus();
        end
        rst    = 1'b0;
        if_req = 1'b0;
        d_req  = 1'b0;
        for (int i = 0; i < 6; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
